// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 DVP capture path: FSM encoding, default
// geometry and a counter-width helper.
package ov5640_pkg;

  localparam int DEF_FRAME_SKIP = 10;
  localparam int DEF_H_PIX      = 640;
  localparam int DEF_V_LINES    = 480;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SKIP     = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_CAPTURE  = 2'd3
  } cap_state_e;

  // Bits needed to hold every value 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ov5640_if.sv
// Camera-side DVP inputs and the assembled RGB565 pixel stream of the capture block.
interface ov5640_if;
  logic        ov5640_href;
  logic        ov5640_vsync;
  logic [7:0]  ov5640_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_eol;

  modport master (
    input  ov5640_href, ov5640_vsync, ov5640_data,
    output pix_data, pix_valid, pix_sof, pix_eol
  );

  modport slave (
    output ov5640_href, ov5640_vsync, ov5640_data,
    input  pix_data, pix_valid, pix_sof, pix_eol
  );
endinterface

// File: rtl/ov5640_byte2pix.sv
// Pairs registered DVP bytes into RGB565 pixels and tracks the horizontal
// pixel count; reports each line end and whether that line was malformed.
module ov5640_byte2pix
  import ov5640_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        en,
  input  logic        href,
  input  logic [7:0]  data,
  input  logic        sof_pend,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        line_end,
  output logic        line_bad
);

  // Counter is one step wider than H_PIX so an over-long line saturates above it.
  localparam int              HW     = cnt_width(H_PIX + 1);
  localparam logic [HW-1:0]   H_MAX  = '1;
  localparam logic [HW-1:0]   H_FULL = HW'(H_PIX);
  localparam logic [HW-1:0]   H_LAST = HW'(H_PIX - 1);

  logic          act;
  logic          act_d;
  logic          fire;
  logic          toggle;
  logic [7:0]    hi_byte;
  logic [HW-1:0] hcnt;

  assign act      = en & href;
  assign fire     = act & toggle;
  assign line_end = act_d & ~act;
  // A set toggle at line end means a trailing odd byte was dropped.
  assign line_bad = line_end & (toggle | (hcnt != H_FULL));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      act_d     <= 1'b0;
      toggle    <= 1'b0;
      hi_byte   <= '0;
      hcnt      <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      act_d     <= act;
      pix_valid <= fire;
      pix_sof   <= fire & sof_pend;
      pix_eol   <= fire & (hcnt == H_LAST);
      if (!act) begin
        toggle <= 1'b0;
        hcnt   <= '0;
      end else begin
        toggle <= ~toggle;
        if (!toggle) begin
          hi_byte <= data;
        end else begin
          pix_data <= {hi_byte, data};
          if (hcnt != H_MAX) hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: registers the sensor bus, skips start-up frames after
// configuration, and emits frame-aligned RGB565 pixels with geometry checking.
module ov5640_capture
  import ov5640_pkg::*;
#(
  parameter int FRAME_SKIP = DEF_FRAME_SKIP,
  parameter int H_PIX      = DEF_H_PIX,
  parameter int V_LINES    = DEF_V_LINES
) (
  input  logic     sclk,
  input  logic     s_rst_n,
  input  logic     cfg_done,
  ov5640_if.master cam,
  output logic     frame_err
);

  localparam int            SW     = cnt_width(FRAME_SKIP);
  localparam int            VW     = cnt_width(V_LINES + 1);
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam logic [VW:0]   V_FULL = (VW+1)'(V_LINES);

  cap_state_e    state, state_nxt;
  logic          href_r, vsync_r, vsync_d;
  logic [7:0]    data_r;
  logic          vs_rise, vs_fall;
  logic          capture_en, err_clr, in_skip;
  logic [SW-1:0] skip_cnt;
  logic          skip_last;
  logic [VW-1:0] vcnt;
  logic [VW:0]   lines_total;
  logic          frame_bad;
  logic          sof_pend;
  logic          line_end, line_bad;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof, pix_eol;

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the pre-edge values of each other, independent of process order.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      href_r  <= 1'b0;
      vsync_r <= 1'b0;
      vsync_d <= 1'b0;
      data_r  <= '0;
    end else begin
      href_r  <= cam.ov5640_href;
      vsync_r <= cam.ov5640_vsync;
      vsync_d <= vsync_r;
      data_r  <= cam.ov5640_data;
    end
  end

  assign vs_rise   = vsync_r & ~vsync_d;
  assign vs_fall   = vsync_d & ~vsync_r;
  assign skip_last = (int'(skip_cnt) == FRAME_SKIP - 1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (!cfg_done) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     state_nxt = (FRAME_SKIP == 0) ? ST_WAIT_SOF : ST_SKIP;
        ST_SKIP:     if (vs_rise && skip_last) state_nxt = ST_WAIT_SOF;
        ST_WAIT_SOF: if (vs_fall) state_nxt = ST_CAPTURE;
        ST_CAPTURE:  state_nxt = ST_CAPTURE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    capture_en = 1'b0;
    err_clr    = 1'b0;
    in_skip    = 1'b0;
    unique case (state)
      ST_IDLE:     err_clr    = cfg_done;
      ST_SKIP:     in_skip    = 1'b1;
      ST_WAIT_SOF: ;
      ST_CAPTURE:  capture_en = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)              skip_cnt <= '0;
    else if (!in_skip)         skip_cnt <= '0;
    else if (vs_rise)          skip_cnt <= skip_cnt + 1'b1;
  end

  // A line cut short by vsync rising ends in the same cycle, so count it here too.
  assign lines_total = {1'b0, vcnt} + {{VW{1'b0}}, line_end};
  assign frame_bad   = capture_en & vs_rise & (lines_total != V_FULL);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vcnt      <= '0;
      sof_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (!capture_en || vs_rise)          vcnt <= '0;
      else if (line_end && vcnt != V_MAX)  vcnt <= vcnt + 1'b1;

      if (state == ST_IDLE) sof_pend <= 1'b0;
      else if (vs_fall)     sof_pend <= (state == ST_WAIT_SOF) || capture_en;
      else if (pix_valid)   sof_pend <= 1'b0;

      if (err_clr)                                   frame_err <= 1'b0;
      else if ((capture_en && line_bad) || frame_bad) frame_err <= 1'b1;
    end
  end

  ov5640_byte2pix #(.H_PIX(H_PIX)) u_byte2pix (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .en        (capture_en & ~vsync_r),
    .href      (href_r),
    .data      (data_r),
    .sof_pend  (sof_pend),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .line_end  (line_end),
    .line_bad  (line_bad)
  );

  assign cam.pix_data  = pix_data;
  assign cam.pix_valid = pix_valid;
  assign cam.pix_sof   = pix_sof;
  assign cam.pix_eol   = pix_eol;

endmodule

// File: doc/ov5640_capture.md
OV5640_CAPTURE -- requirements
Module: ov5640_capture

Interface
REQ-001 Parameter FRAME_SKIP, default 10: number of complete frames discarded after cfg_done before output starts.
REQ-002 Parameter H_PIX, default 640: expected 16-bit pixels per line.
REQ-003 Parameter V_LINES, default 480: expected lines per frame.
REQ-004 sclk  in  1  single clock, driven by the camera pixel clock (ov5640_pclk); all logic rises on it.
REQ-005 s_rst_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_done  in  1  level, high once SCCB configuration has completed; capture is gated by it.
REQ-007 ov5640_href  in  1  line-valid from sensor.
REQ-008 ov5640_vsync  in  1  frame sync from sensor, active high between frames.
REQ-009 ov5640_data  in  8  DVP byte, RGB565 high byte first.
REQ-010 pix_data  out  16  assembled RGB565 pixel {first byte, second byte}.
REQ-011 pix_valid  out  1  one-cycle qualifier for pix_data.
REQ-012 pix_sof  out  1  high with the first pix_valid of a frame.
REQ-013 pix_eol  out  1  high with the last pix_valid of a line.
REQ-014 frame_err  out  1  sticky error flag: line length, line count or odd byte mismatch.

Function
REQ-015 The block SHALL register href, vsync and data in one input stage; all decisions use the registered copies.
REQ-016 The block SHALL detect frame start on the registered vsync falling edge and frame end on its rising edge.
REQ-017 FSM states SHALL be IDLE, SKIP, WAIT_SOF and CAPTURE.
REQ-018 IDLE -> SKIP when cfg_done is high; any state -> IDLE when cfg_done falls.
REQ-019 SKIP SHALL count vsync rising edges; -> WAIT_SOF once FRAME_SKIP edges are counted; FRAME_SKIP=0 goes directly to WAIT_SOF.
REQ-020 WAIT_SOF -> CAPTURE on the next vsync falling edge, so output always begins at a frame boundary.
REQ-021 In CAPTURE, while registered href is high, a byte toggle SHALL alternate; even byte latched as high byte, odd byte completes the pixel.
REQ-022 pix_valid SHALL pulse in the cycle after the odd byte sits in the input register; latency from second byte on pins to pix_valid is 2 sclk cycles.
REQ-023 The byte toggle SHALL clear whenever registered href is low; a trailing odd byte is dropped and sets frame_err.
REQ-024 pix_eol SHALL accompany the pixel whose horizontal count equals H_PIX-1; the horizontal count saturates and is not wrapped.
REQ-025 On the href falling edge, a horizontal count other than H_PIX SHALL set frame_err; the count then clears and the line count increments.
REQ-026 On vsync rising edge in CAPTURE, a line count other than V_LINES SHALL set frame_err; the line count clears.
REQ-027 pix_sof SHALL be high only on the first pix_valid after a vsync falling edge.
REQ-028 href high in any state other than CAPTURE SHALL produce no output.
REQ-029 vsync rising while href is still high SHALL end the line as in REQ-025, then end the frame.
REQ-030 frame_err SHALL clear only on reset or on the IDLE -> SKIP transition.

Reset
REQ-031 While s_rst_n is low: FSM = IDLE; counters and toggle = 0; pix_data = 0; pix_valid, pix_sof, pix_eol and frame_err = 0; input registers = 0.
REQ-032 Reset assertion mid-line SHALL abort immediately with no partial pixel emitted; after release, capture restarts from IDLE, including the frame skip.

Structure
REQ-033 FSM state encodings and default H_PIX, V_LINES and FRAME_SKIP values SHALL live in the shared package ov5640_pkg.
REQ-034 Byte pairing and horizontal counting MAY be a sub-module ov5640_byte2pix; FSM, vsync edge logic and error logic stay in the top.
REQ-035 The block is instantiated in the camera top level beside the configuration block, with cfg_done derived from that block's completion.

Verification
REQ-036 FRAME_SKIP=2, H_PIX=4, V_LINES=2, cfg_done high, 4 frames of bytes 0x00..0x07 per line -> no output for frames 1-2; frame 3 yields pix_data 0x0001, 0x0203, 0x0405, 0x0607 per line, pix_sof on the first, pix_eol on 0x0607, frame_err=0.
REQ-037 Line of 7 bytes in CAPTURE -> 3 pixels, no pix_eol, frame_err=1 held until cfg_done is cycled.
REQ-038 Second byte on pins at edge N -> pix_valid high exactly at edge N+2, one cycle wide.
REQ-039 Frame with 3 lines when V_LINES=2 -> frame_err=1 at the vsync rising edge.
REQ-040 s_rst_n pulsed low after 3 bytes of a line -> all outputs 0 asynchronously; after release, no pixel until FRAME_SKIP frames plus a new frame start.
REQ-041 cfg_done low, full frames driven -> pix_valid never asserts; raise cfg_done in the middle of a frame -> first output pix_sof only after the skip count and the next vsync falling edge.
